// File: rtl/strobe_stall_pkg.sv
`default_nettype none
// ============================================================================
// Module      : strobe_stall_pkg
// Description : Shared constants and helpers for the strobe/stall merger.
//               The per-channel count array type lives in strobe_stall_merge
//               because its element width follows that module's CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
package strobe_stall_pkg;

    // Default channel count and pending-counter width
    localparam int NUM_CHAN_DEF = 4;
    localparam int CNT_W_DEF    = 4;

    // Index width that stays at least one bit wide for a single channel
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : strobe_stall_pkg
`default_nettype wire

// File: rtl/strobe_stall_merge_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request found searching upward from i_ptr, wrapping at
//               NUM_CHAN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import strobe_stall_pkg::*;
#(
    parameter int NUM_CHAN = NUM_CHAN_DEF,
    parameter int CHAN_W   = clog2_min1(NUM_CHAN)
) (
    input  logic [NUM_CHAN-1:0] i_req,
    input  logic [CHAN_W-1:0]   i_ptr,
    output logic [NUM_CHAN-1:0] o_grant,
    output logic [CHAN_W-1:0]   o_grant_idx,
    output logic                o_any
);

    // Walk the channels in priority order starting at the pointer; first hit wins
    always_comb begin
        int v_idx;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        v_idx       = 0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            v_idx = (int'(i_ptr) + k) % NUM_CHAN;
            if (!o_any && i_req[v_idx]) begin
                o_any          = 1'b1;
                o_grant[v_idx] = 1'b1;
                o_grant_idx    = CHAN_W'(v_idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/strobe_stall_merge.sv
`default_nettype none
// ============================================================================
// Module      : strobe_stall_merge
// Description : N-channel strobe/stall event merger. Counts pending events
//               per channel and drains them round-robin onto one registered
//               strobe/stall output tagged with the source channel index.
//               Events arriving at a full counter are dropped and flagged in
//               a sticky per-channel overflow bit.
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_stall_merge
    import strobe_stall_pkg::*;
#(
    parameter int NUM_CHAN = NUM_CHAN_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    // Derived from NUM_CHAN; leave at its default
    parameter int CHAN_W   = clog2_min1(NUM_CHAN)
) (
    input  logic                      dest_clk,
    input  logic                      dest_reset_n,
    input  logic [NUM_CHAN-1:0]       chan_strobe,
    output logic [NUM_CHAN-1:0]       chan_stall,
    output logic                      out_strobe,
    output logic [CHAN_W-1:0]         out_chan,
    input  logic                      out_stall,
    input  logic                      clear_overflow,
    output logic [NUM_CHAN-1:0]       chan_overflow,
    output logic [NUM_CHAN*CNT_W-1:0] chan_pending
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t c_cnt_max = '1;

    // Pending counts exclude the event currently held in the output register
    cnt_t                r_cnt [NUM_CHAN];
    logic                r_out_strobe;
    logic [CHAN_W-1:0]   r_out_chan;
    logic [CHAN_W-1:0]   r_ptr;
    logic [NUM_CHAN-1:0] r_ovf;

    logic [NUM_CHAN-1:0] w_stall;
    logic [NUM_CHAN-1:0] w_req;
    logic [NUM_CHAN-1:0] w_accept;
    logic [NUM_CHAN-1:0] w_dec;
    logic [NUM_CHAN-1:0] w_grant;
    logic [CHAN_W-1:0]   w_grant_idx;
    logic                w_any;
    logic                w_load;
    logic [CHAN_W-1:0]   w_ptr_nxt;

    // Per-channel status derived from the registered counts
    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        assign w_stall[i]                     = (r_cnt[i] == c_cnt_max);
        assign w_req[i]                       = (r_cnt[i] != '0);
        assign chan_pending[i*CNT_W +: CNT_W] = r_cnt[i];
    end

    // An event is accepted only while its counter has room
    assign w_accept = chan_strobe & ~w_stall;

    // Output register may take a new event when empty or being consumed
    assign w_load = !r_out_strobe || !out_stall;

    // Only the granted channel is decremented, and only when the register loads
    assign w_dec = w_grant & {NUM_CHAN{w_load}};

    // Pointer moves one past the winner so it gets lowest priority next time
    assign w_ptr_nxt = (w_grant_idx == CHAN_W'(NUM_CHAN - 1)) ? '0
                                                              : w_grant_idx + 1'b1;

    rr_arbiter #(
        .NUM_CHAN (NUM_CHAN),
        .CHAN_W   (CHAN_W)
    ) u_arb (
        .i_req       (w_req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // Pending counters: accept and grant in the same cycle cancel out
    always_ff @(posedge dest_clk or negedge dest_reset_n) begin
        if (!dest_reset_n) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                if (w_accept[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (!w_accept[i] && w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Output register and round-robin pointer; contents hold while stalled
    always_ff @(posedge dest_clk or negedge dest_reset_n) begin
        if (!dest_reset_n) begin
            r_out_strobe <= 1'b0;
            r_out_chan   <= '0;
            r_ptr        <= '0;
        end else if (w_load) begin
            r_out_strobe <= w_any;
            if (w_any) begin
                r_out_chan <= w_grant_idx;
                r_ptr      <= w_ptr_nxt;
            end
        end
    end

    // Sticky overflow flags; a new drop takes precedence over the clear
    always_ff @(posedge dest_clk or negedge dest_reset_n) begin
        if (!dest_reset_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~{NUM_CHAN{clear_overflow}}) | (chan_strobe & w_stall);
        end
    end

    assign chan_stall    = w_stall;
    assign out_strobe    = r_out_strobe;
    assign out_chan      = r_out_chan;
    assign chan_overflow = r_ovf;

endmodule : strobe_stall_merge
`default_nettype wire

// File: tb/tb_strobe_stall_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_strobe_stall_merge
// Description : Directed self-checking bench for strobe_stall_merge with an
//               event-level reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strobe_stall_merge;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int MAX = 15;

    logic        clk;
    logic        rst_n;
    logic [3:0]  strobe;
    logic        stall_in;
    logic        clr;
    logic [3:0]  chan_stall;
    logic        out_strobe;
    logic [1:0]  out_chan;
    logic [3:0]  chan_overflow;
    logic [15:0] chan_pending;

    int n_total;
    int n_bad;

    strobe_stall_merge #(
        .NUM_CHAN (N),
        .CNT_W    (CW)
    ) dut (
        .dest_clk       (clk),
        .dest_reset_n   (rst_n),
        .chan_strobe    (strobe),
        .chan_stall     (chan_stall),
        .out_strobe     (out_strobe),
        .out_chan       (out_chan),
        .out_stall      (stall_in),
        .clear_overflow (clr),
        .chan_overflow  (chan_overflow),
        .chan_pending   (chan_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: events waiting per channel, one output slot, fair pointer
    int       m_cnt [N];
    bit       m_vld;
    int       m_chan;
    int       m_ptr;
    bit [3:0] m_ovf;

    always @(posedge clk or negedge rst_n) begin
        int       g;
        bit [3:0] full;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_vld  = 0;
            m_chan = 0;
            m_ptr  = 0;
            m_ovf  = '0;
        end else begin
            for (int i = 0; i < N; i++) full[i] = (m_cnt[i] == MAX);
            if (!m_vld || !stall_in) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && m_cnt[(m_ptr + k) % N] > 0) g = (m_ptr + k) % N;
                if (g >= 0) begin
                    m_vld  = 1;
                    m_chan = g;
                    m_ptr  = (g + 1) % N;
                    m_cnt[g]--;
                end else begin
                    m_vld = 0;
                end
            end
            if (clr) m_ovf = '0;
            for (int i = 0; i < N; i++) begin
                if (strobe[i]) begin
                    if (full[i]) m_ovf[i] = 1;
                    else         m_cnt[i]++;
                end
            end
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge
    always @(negedge clk) begin
        logic [15:0] ep;
        logic [3:0]  es;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                ep[i*CW +: CW] = 4'(m_cnt[i]);
                es[i]          = (m_cnt[i] == MAX);
            end
            chk("m_out_strobe", out_strobe, m_vld);
            if (m_vld) chk("m_out_chan", out_chan, m_chan);
            chk("m_chan_stall", chan_stall, es);
            chk("m_chan_pending", chan_pending, ep);
            chk("m_chan_overflow", chan_overflow, m_ovf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int q[$];
        int n;
        n_total  = 0;
        n_bad    = 0;
        strobe   = '0;
        stall_in = 1'b0;
        clr      = 1'b0;
        rst_n    = 1'b0;
        #2;
        chk("rst_out_strobe", out_strobe, 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_pending", chan_pending, 0);
        chk("rst_stall", chan_stall, 0);
        chk("rst_ovf", chan_overflow, 0);
        do_reset();

        // 1: single event on ch2 appears two cycles later, for one cycle
        strobe = 4'b0100; cyc();
        strobe = 4'b0000; cyc();
        @(negedge clk);
        chk("t1_strobe", out_strobe, 1);
        chk("t1_chan", out_chan, 2);
        chk("t1_pending", chan_pending, 0);
        cyc();
        @(negedge clk);
        chk("t1_strobe_off", out_strobe, 0);

        // 2: all channels at once drain in order 0..3 from a fresh pointer
        do_reset();
        strobe = 4'b1111; cyc();
        strobe = 4'b0000; cyc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_strobe", out_strobe, 1);
            chk("t2_chan", out_chan, k);
            cyc();
        end
        @(negedge clk);
        chk("t2_strobe_off", out_strobe, 0);

        // 3: continuous ch0/ch3 traffic alternates fairly
        cyc();
        for (int c = 0; c < 30; c++) begin
            strobe = (c < 8) ? 4'b1001 : 4'b0000;
            @(negedge clk);
            if (out_strobe) q.push_back(int'(out_chan));
            cyc();
        end
        chk("t3_count", q.size(), 16);
        for (int k = 0; k < q.size(); k++) chk("t3_seq", q[k], (k % 2) ? 3 : 0);

        // 4: fill ch1 under backpressure, overflow, clear, then drain
        stall_in = 1'b1;
        for (int k = 0; k < 16; k++) begin
            strobe = 4'b0010; cyc();
        end
        strobe = 4'b0000;
        @(negedge clk);
        chk("t4_pending", chan_pending, 16'h00F0);
        chk("t4_stall", chan_stall, 4'b0010);
        chk("t4_ovf0", chan_overflow, 0);
        chk("t4_held_chan", out_chan, 1);
        cyc();
        strobe = 4'b0010; cyc();
        strobe = 4'b0000;
        @(negedge clk);
        chk("t4_ovf_set", chan_overflow, 4'b0010);
        chk("t4_pending_sat", chan_pending, 16'h00F0);
        cyc();
        clr = 1'b1; cyc();
        clr = 1'b0;
        @(negedge clk);
        chk("t4_ovf_clr", chan_overflow, 0);
        cyc();
        stall_in = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_strobe && !stall_in) begin
                n++;
                chk("t4_drain_chan", out_chan, 1);
            end
            cyc();
        end
        chk("t4_transfers", n, 16);

        // 5: accept and grant on ch2 in the same cycle leave the count at 3
        stall_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            strobe = 4'b0100; cyc();
        end
        strobe = 4'b0000;
        @(negedge clk);
        chk("t5_pending_pre", chan_pending, 16'h0300);
        cyc();
        stall_in = 1'b0;
        strobe   = 4'b0100; cyc();
        strobe   = 4'b0000;
        @(negedge clk);
        chk("t5_pending", chan_pending, 16'h0300);
        chk("t5_strobe", out_strobe, 1);
        chk("t5_chan", out_chan, 2);
        repeat (8) cyc();

        // 6: asynchronous reset mid-drain clears everything immediately
        stall_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            strobe = 4'b0001; cyc();
        end
        strobe   = 4'b0000;
        stall_in = 1'b0;
        cyc();
        #2;
        chk("t6_pending_pre", chan_pending, 16'h0005);
        chk("t6_strobe_pre", out_strobe, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_strobe", out_strobe, 0);
        chk("t6_rst_chan", out_chan, 0);
        chk("t6_rst_pending", chan_pending, 0);
        chk("t6_rst_stall", chan_stall, 0);
        chk("t6_rst_ovf", chan_overflow, 0);
        cyc();
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_strobe) n++;
            cyc();
        end
        chk("t6_no_ghost", n, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_strobe_stall_merge
`default_nettype wire

// File: doc/strobe_stall_merge.md
Name: strobe_stall_merge

Overview:
- N-channel strobe/stall event merger in the destination clock domain.
- Each channel delivers single-cycle event strobes, for example from per-channel CDC handshake instances.
- The block counts pending events per channel and drains them round-robin onto one strobe/stall output tagged with the channel index.
- Compared with a single-channel handshake it adds:
  - a channel-count parameter;
  - per-channel event queuing (counter depth);
  - fair arbitration;
  - overflow detection.

Parameters:
- NUM_CHAN, 4, number of input channels (1..32).
- CNT_W, 4, pending-counter width; max pending per channel = 2**CNT_W-1.
- CHAN_W, (NUM_CHAN>1 ? $clog2(NUM_CHAN) : 1), width of out_chan; derived, do not override.

Ports:
- dest_clk  in  1  single clock; all logic on rising edge.
- dest_reset_n  in  1  asynchronous assert, active-low reset.
- chan_strobe  in  NUM_CHAN  per-channel event strobe.
- chan_stall  out  NUM_CHAN  per-channel backpressure; high when that counter is at max.
- out_strobe  out  1  merged event valid.
- out_chan  out  CHAN_W  channel index of the current out_strobe.
- out_stall  in  1  downstream backpressure.
- clear_overflow  in  1  single-cycle clear of all overflow flags.
- chan_overflow  out  NUM_CHAN  sticky: an event arrived while the channel was stalled.
- chan_pending  out  NUM_CHAN*CNT_W  packed per-channel pending counts, status only.

Behaviour:
- Transfer rules:
  - Input transfer on channel i: chan_strobe[i]=1 and chan_stall[i]=0 in the same cycle.
  - Output transfer: out_strobe=1 and out_stall=0.
- Reset (async, dest_reset_n=0):
  - All counters = 0; chan_stall = 0; out_strobe = 0; out_chan = 0.
  - RR pointer = 0; chan_overflow = 0.
  - A reset mid-operation discards all pending and in-flight events, with no partial output.
- Counter i, next value:
  - +1 on input accept;
  - -1 when channel i is granted;
  - unchanged if both happen in the same cycle.
  - Never wraps.
- chan_stall[i] = (count[i] == 2**CNT_W-1). Combinational from the registered count.
- Dropped events: chan_strobe[i] while chan_stall[i]=1 is dropped and sets chan_overflow[i]. If clear_overflow and a new overflow occur in the same cycle, set wins.
- Output register (out_strobe, out_chan):
  - Loads when !out_strobe || !out_stall.
  - On load: if any count>0, grant the first nonzero channel searching from the RR pointer upward with wrap. Set out_strobe=1, out_chan=grant, decrement that count, pointer = grant+1 (mod NUM_CHAN).
  - On load with all counts 0: out_strobe=0.
  - While out_stall=1 and out_strobe=1: out_strobe and out_chan hold stable.
- Latency: an event accepted in cycle c (idle block) gives out_strobe in cycle c+2.
- Throughput: one event per cycle when out_stall=0.
- chan_pending excludes the event held in the output register.
- NUM_CHAN=1: out_chan is constantly 0; the arbiter degenerates to a pass-through.

Decomposition:
- Package strobe_stall_pkg:
  - function clog2_min1;
  - localparam default values;
  - typedef for the count array, parameterised by CNT_W via the module.
- Sub-module rr_arbiter (NUM_CHAN):
  - inputs: request vector, pointer;
  - outputs: one-hot grant, grant index, any_grant;
  - purely combinational.
- Counters, output register and pointer stay in strobe_stall_merge.

Test Plan:
1. Idle: chan_strobe=4'b0100 for one cycle, out_stall=0 -> two cycles later out_strobe=1 for exactly one cycle with out_chan=2; chan_pending all 0 afterwards.
2. chan_strobe=4'b1111 in one cycle, out_stall=0 -> out_strobe high for 4 consecutive cycles, out_chan sequence 0,1,2,3; pointer ends at 0.
3. Continuous strobes on ch0 and ch3 for 8 cycles, out_stall=0 -> out_chan alternates 0,3,0,3,...; no channel is granted twice while the other has a count>0.
4. out_stall=1 held while ch1 strobes 16 times:
   - The first event loads the output register; 15 events are counted; chan_pending[1]=15; chan_stall[1]=1.
   - A 17th strobe sets chan_overflow[1]=1 and leaves the count at 15.
   - clear_overflow clears the flag.
   - Release out_stall -> exactly 16 out_strobe transfers on ch1.
5. Same-cycle accept and grant on ch2 with count=3 -> count stays 3; out_chan=2.
6. Assert dest_reset_n=0 asynchronously mid-drain with count=5 and out_strobe=1 -> outputs go to their reset values immediately, without waiting for a clock edge. After release, no out_strobe occurs without new chan_strobe.
